// File: rtl/b2e_pkg.sv
// Shared BCD constants and helpers for the digit scanner and its blank mask.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package b2e_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_BLANK = 4'b1111;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Upper bound on scanned digits; callers cast the result down to their width.
  localparam int MAX_DIGITS = 32;

  // One-hot code of a digit index, LSB = digit 0.
  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
    return MAX_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/bcd_blank_mask.sv
// Per-digit blank mask: invalid BCD nibbles and (optionally) leading zeros.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module bcd_blank_mask
  import b2e_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [NUM_DIGITS*BCD_W-1:0] disp,
  input  logic                        blank_lz,
  output logic [NUM_DIGITS-1:0]       mask
);

  logic [BCD_W-1:0] nib;
  logic             upper_zero;

  // Walk from the most significant digit down, tracking whether every nibble
  // seen so far is zero; digit 0 is exempt so a zero value still shows "0".
  always_comb begin
    mask       = '0;
    nib        = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib        = disp[k*BCD_W +: BCD_W];
      upper_zero = upper_zero && (nib == '0);
      mask[k]    = (nib > BCD_MAX) || (blank_lz && upper_zero && (k != 0));
    end
  end

endmodule

// File: rtl/bcd_digit_scanner.sv
// Time-multiplexes a multi-digit BCD value onto one 4-bit bus with one-hot digit enables.
// Latency: a load commits at the next frame boundary; outputs decode straight from registers.
// Backpressure: load_ready low while a load is pending; new loads wait for the commit.
module bcd_digit_scanner
  import b2e_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [4*NUM_DIGITS-1:0]     load_data,
  input  logic                        blank_lz,
  output logic [3:0]                  bcd_out,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        blank
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  // DWELL=1 still needs a one-bit counter; it simply stays at zero.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0]     disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0]     pend_q, pend_d;
  logic                        pend_full_q, pend_full_d;

  logic                        cnt_last;
  logic                        frame_end;
  logic                        load_fire;
  logic [NUM_DIGITS-1:0]       blank_mask;
  logic [BCD_W-1:0]            cur_nib;

  assign load_ready = ~pend_full_q;

  // Next-state: dwell counter, digit index, pending buffer and frame-aligned commit.
  always_comb begin
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;

    cnt_last  = (cnt_q == CNT_LAST);
    frame_end = cnt_last && (idx_q == IDX_LAST);
    load_fire = load_valid && !pend_full_q;

    if (cnt_last) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Only a value that was already pending when the boundary cycle began is
    // committed; a load landing on the boundary waits a whole frame.
    if (frame_end && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end

    // Acceptance requires the buffer to be empty, so it never collides with a commit.
    if (load_fire) begin
      pend_d      = load_data;
      pend_full_d = 1'b1;
    end
  end

  // State registers with synchronous reset; a load in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end

  bcd_blank_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_blank_mask (
    .disp     (disp_q),
    .blank_lz (blank_lz),
    .mask     (blank_mask)
  );

  // Output decode directly from registered index and display value.
  always_comb begin
    digit_en = NUM_DIGITS'(onehot(32'(idx_q)));
    cur_nib  = disp_q[idx_q*BCD_W +: BCD_W];
    blank    = blank_mask[idx_q];
    bcd_out  = blank ? BCD_BLANK : cur_nib;
  end

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Directed bench for bcd_digit_scanner with NUM_DIGITS=4, DWELL=3 (12-cycle frame).
// Inputs change and outputs are sampled on the falling clock edge.
// A bench-side phase counter tracks position in the frame.
module tb_bcd_digit_scanner;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        blank_lz;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_en;
  logic        blank;

  int checks   = 0;
  int failures = 0;
  int phase    = 0;

  bcd_digit_scanner #(
    .NUM_DIGITS (4),
    .DWELL      (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank_lz   (blank_lz),
    .bcd_out    (bcd_out),
    .digit_en   (digit_en),
    .blank      (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       lz;
    logic [3:0] en;
    logic [3:0] bcd;
    logic       blk;
    logic       rdy;
  } vec_t;

  vec_t vec [24];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    phase = (phase == 11) ? 0 : phase + 1;
    @(negedge clk);
  endtask

  // Expected per-digit bus values packed as nibbles, plus the expected blank bits.
  task automatic check_cycle(input string nm, input logic [15:0] exp, input logic [3:0] msk,
                             input logic rdy);
    int d;
    logic [15:0] e;
    logic [3:0]  oh;
    d  = phase / 3;
    e  = exp;
    oh = 4'b0001 << d;
    #1;
    chk($sformatf("%s_en_p%0d", nm, phase), 16'(digit_en), 16'(oh));
    chk($sformatf("%s_bcd_p%0d", nm, phase), 16'(bcd_out), 16'(e[d*4 +: 4]));
    chk($sformatf("%s_blank_p%0d", nm, phase), 16'(blank), 16'(msk[d]));
    chk($sformatf("%s_rdy_p%0d", nm, phase), 16'(load_ready), 16'(rdy));
  endtask

  // Check from the current phase until the next frame start.
  task automatic check_frame(input string nm, input logic [15:0] exp, input logic [3:0] msk,
                             input logic rdy);
    for (int i = 0; i < 12; i++) begin
      check_cycle(nm, exp, msk, rdy);
      tick();
      if (phase == 0) break;
    end
  endtask

  task automatic load_at(input string nm, input logic [15:0] data, input logic [15:0] cur,
                         input logic [3:0] cur_msk);
    check_cycle(nm, cur, cur_msk, 1'b1);
    load_valid = 1'b1;
    load_data  = data;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    blank_lz   = 1'b0;

    // Reset scan: frame with blank_lz=0, then a frame with blank_lz=1 on value 0.
    vec[0]  = '{1'b0, 4'b0001, 4'h0, 1'b0, 1'b1};
    vec[1]  = '{1'b0, 4'b0001, 4'h0, 1'b0, 1'b1};
    vec[2]  = '{1'b0, 4'b0001, 4'h0, 1'b0, 1'b1};
    vec[3]  = '{1'b0, 4'b0010, 4'h0, 1'b0, 1'b1};
    vec[4]  = '{1'b0, 4'b0010, 4'h0, 1'b0, 1'b1};
    vec[5]  = '{1'b0, 4'b0010, 4'h0, 1'b0, 1'b1};
    vec[6]  = '{1'b0, 4'b0100, 4'h0, 1'b0, 1'b1};
    vec[7]  = '{1'b0, 4'b0100, 4'h0, 1'b0, 1'b1};
    vec[8]  = '{1'b0, 4'b0100, 4'h0, 1'b0, 1'b1};
    vec[9]  = '{1'b0, 4'b1000, 4'h0, 1'b0, 1'b1};
    vec[10] = '{1'b0, 4'b1000, 4'h0, 1'b0, 1'b1};
    vec[11] = '{1'b0, 4'b1000, 4'h0, 1'b0, 1'b1};
    vec[12] = '{1'b1, 4'b0001, 4'h0, 1'b0, 1'b1};
    vec[13] = '{1'b1, 4'b0001, 4'h0, 1'b0, 1'b1};
    vec[14] = '{1'b1, 4'b0001, 4'h0, 1'b0, 1'b1};
    vec[15] = '{1'b1, 4'b0010, 4'hF, 1'b1, 1'b1};
    vec[16] = '{1'b1, 4'b0010, 4'hF, 1'b1, 1'b1};
    vec[17] = '{1'b1, 4'b0010, 4'hF, 1'b1, 1'b1};
    vec[18] = '{1'b1, 4'b0100, 4'hF, 1'b1, 1'b1};
    vec[19] = '{1'b1, 4'b0100, 4'hF, 1'b1, 1'b1};
    vec[20] = '{1'b1, 4'b0100, 4'hF, 1'b1, 1'b1};
    vec[21] = '{1'b1, 4'b1000, 4'hF, 1'b1, 1'b1};
    vec[22] = '{1'b1, 4'b1000, 4'hF, 1'b1, 1'b1};
    vec[23] = '{1'b1, 4'b1000, 4'hF, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    phase = 0;

    // 1. Reset values and scan order.
    for (int i = 0; i < 24; i++) begin
      blank_lz = vec[i].lz;
      #1;
      chk($sformatf("scan_en_%0d", i), 16'(digit_en), 16'(vec[i].en));
      chk($sformatf("scan_bcd_%0d", i), 16'(bcd_out), 16'(vec[i].bcd));
      chk($sformatf("scan_blank_%0d", i), 16'(blank), 16'(vec[i].blk));
      chk($sformatf("scan_rdy_%0d", i), 16'(load_ready), 16'(vec[i].rdy));
      tick();
    end
    blank_lz = 1'b0;

    // 2. Mid-frame load waits for the boundary.
    while (phase != 5) tick();
    load_at("ld1234", 16'h1234, 16'h0000, 4'b0000);
    check_frame("wait1234", 16'h0000, 4'b0000, 1'b0);
    check_frame("show1234", 16'h1234, 4'b0000, 1'b1);

    // 3. Leading-zero suppression.
    blank_lz = 1'b1;
    load_at("ld0070", 16'h0070, 16'h1234, 4'b0000);
    check_frame("wait0070", 16'h1234, 4'b0000, 1'b0);
    check_frame("show0070", 16'hFF70, 4'b1100, 1'b1);
    load_at("ld0000", 16'h0000, 16'hFF70, 4'b1100);
    check_frame("wait0000", 16'hFF70, 4'b1100, 1'b0);
    check_frame("show0000", 16'hFFF0, 4'b1110, 1'b1);
    // blank_lz takes effect in the same cycle, without waiting for a frame.
    tick(); tick(); tick();
    check_cycle("lz_on", 16'hFFF0, 4'b1110, 1'b1);
    blank_lz = 1'b0;
    check_frame("lz_off", 16'h0000, 4'b0000, 1'b1);

    // 4. Invalid BCD nibble is blanked regardless of blank_lz.
    load_at("ld12A4", 16'h12A4, 16'h0000, 4'b0000);
    check_frame("wait12A4", 16'h0000, 4'b0000, 1'b0);
    check_frame("show12A4", 16'h12F4, 4'b0010, 1'b1);

    // 5. Load on the boundary cycle; a second load while busy is ignored.
    while (phase != 11) begin
      check_cycle("pre5555", 16'h12F4, 4'b0010, 1'b1);
      tick();
    end
    load_at("ld5555", 16'h5555, 16'h12F4, 4'b0010);
    load_valid = 1'b1;
    load_data  = 16'h9999;
    for (int i = 0; i < 12; i++) begin
      if (phase == 11) load_valid = 1'b0;
      check_cycle("hold12A4", 16'h12F4, 4'b0010, 1'b0);
      tick();
    end
    load_valid = 1'b0;
    check_frame("show5555a", 16'h5555, 4'b0000, 1'b1);
    check_frame("show5555b", 16'h5555, 4'b0000, 1'b1);

    // 6. Reset with a load pending discards it; a load during reset is dropped.
    load_at("ld8888", 16'h8888, 16'h5555, 4'b0000);
    while (phase != 6) begin
      check_cycle("pend8888", 16'h5555, 4'b0000, 1'b0);
      tick();
    end
    rst        = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h7777;
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    load_valid = 1'b0;
    phase      = 0;
    check_frame("after_rst_a", 16'h0000, 4'b0000, 1'b1);
    check_frame("after_rst_b", 16'h0000, 4'b0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
